enc4to2_seq: RTL
================

Name: enc4to2_seq

Overview:
- Sequential counterpart of the 2-to-4 decoder. Accepts an N-bit multi-hot request word through a valid/ready handshake.
- Emits the binary index of every set bit, lowest first, one index per output handshake.
- Converts decoder-style select/strobe lines back into a stream of binary codes for downstream arbitration and logging.

Parameters:
- N, 4, number of request lines; power of two, N >= 2.
- AW, 2, index width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled only on the clk rising edge.
- en  input  1  global enable; when low, blocks input acceptance and pauses output.
- s  input  N  request word; bit i requests code i.
- s_valid  input  1  request word valid.
- s_ready  output  1  block can accept a word; combinational: (state==IDLE) && en.
- a  output  AW  current binary index, registered.
- a_valid  output  1  a is valid, registered.
- a_ready  input  1  downstream consumes a.
- remain  output  AW+1  number of indices still to emit, including the one on a; registered.
- zero_err  output  1  one-cycle pulse: a word with s==0 was accepted; registered.
- busy  output  1  state==SERVE.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, pending=0, a=0, a_valid=0, remain=0, zero_err=0. Applies even mid-SERVE; undelivered indices are dropped.
- States: IDLE, SERVE. The internal register pending (N bits) holds the undelivered requests.
- Accept occurs when s_valid && s_ready at an edge.
- IDLE, accept with s!=0: pending<=s, remain<=popcount(s), a<=index of lowest set bit of s, a_valid<=1, state<=SERVE. a_valid is high in the cycle after the accept edge (latency 1).
- IDLE, accept with s==0: zero_err<=1 for exactly one cycle; state stays IDLE; a_valid stays 0.
- IDLE, no accept: zero_err<=0; all else held.
- SERVE, en=1, a_valid && a_ready at an edge: clear the bit a in pending and decrement remain.
  - If bits remain: a<=next lowest set bit, a_valid stays 1. There is no bubble between codes.
  - If none remain: a_valid<=0, remain<=0, state<=IDLE. s_ready rises in the following cycle.
- SERVE, en=0: a_valid<=0; pending, a and remain are held; a_ready is ignored. When en returns to 1, a_valid<=1 with the same a one cycle later.
- a_ready while a_valid=0: ignored.
- s_valid during SERVE: not accepted (s_ready=0). The upstream holds the word.
- en=0 in IDLE: s_ready=0; nothing is accepted.
- Output ordering is strictly ascending index within one word. Example: s=4'b1111 yields a=0,1,2,3.
- A single-bit word yields exactly one index, then returns to IDLE. Minimum period is 2 cycles per word with a_ready held high.
- Width rules:
  - remain is AW+1 bits so it can hold N.
  - popcount is computed at width AW+1.
  - Index values never exceed N-1.

Decomposition:
- Package enc_pkg holds:
  - the state localparams ST_IDLE=1'b0 and ST_SERVE=1'b1;
  - a popcount function parameterised by N;
  - the default N and AW.
- Sub-module lsb_find (combinational): input vec[N-1:0]; outputs idx[AW-1:0] and any. It finds the lowest set bit and is instantiated twice: once on s for load, once on the next-pending value for advance. All registers live in enc4to2_seq.

Test Plan:
- Reset mid-SERVE: load s=4'b1111, consume one code, pull rst_n low for one edge. Required: a_valid=0, remain=0, busy=0, s_ready=1 next cycle with en=1; a later s=4'b0100 yields a=2 only.
- Full word, a_ready held high: s=4'b1111 accepted at cycle 0. Required: a=0,1,2,3 on cycles 1-4 with a_valid=1 and remain=4,3,2,1; a_valid=0 and busy=0 on cycle 5; s_ready=1 on cycle 5.
- Sparse word with backpressure: s=4'b1010, a_ready low for 3 cycles then high. Required: a=1 held stable with remain=2 while stalled, then a=3 with remain=1, then IDLE.
- Zero word: s=4'b0000 with s_valid=1, en=1. Required: zero_err=1 for exactly one cycle, a_valid never asserted, state stays IDLE.
- Enable pause: s=4'b0110 accepted, en=0 after the first handshake. Required: a_valid=0 and a=2, remain=1 held during pause; a=2, a_valid=1 one cycle after en=1; s_valid ignored while en=0.
- Exhaustive: all 16 values of s with random a_ready. Required: the emitted index set equals the set bits of s, ascending, with no duplicates; zero_err only for s=0.

Source files
------------

// File: rtl/enc_pkg.sv
// enc_pkg: shared defaults, FSM state codes and popcount helper for enc4to2_seq
//   DEF_N / DEF_AW : default request width and index width
//   ST_IDLE / ST_SERVE : state register encodings
//   popcount(v, n) : number of set bits among the low n bits of v
package enc_pkg;
    localparam int DEF_N = 4;
    localparam int DEF_AW = 2;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SERVE = 1'b1;
    function automatic int popcount(input logic [63:0] v, input int n);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++) c += (i < n && v[i]) ? 1 : 0;
        return c;
    endfunction
endpackage

// File: rtl/lsb_find.sv
// lsb_find: combinational lowest-set-bit locator
//   vec : input request vector
//   idx : index of the lowest set bit of vec (0 when vec is empty)
//   any : vec has at least one bit set
module lsb_find #(
    parameter int N = 4,
    parameter int AW = 2
) (
    input  logic [N-1:0]  vec,
    output logic [AW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        any = |vec;
        // scanning downward lets the lowest set bit win
        for (int i = N - 1; i >= 0; i--) if (vec[i]) idx = AW'(i);
    end
endmodule

// File: rtl/enc4to2_seq.sv
// enc4to2_seq: streams the binary index of every set request bit, lowest first
//   clk, rst_n        : clock, synchronous active-low reset
//   en                : global enable; low blocks acceptance and pauses output
//   s, s_valid, s_ready : multi-hot request word handshake
//   a, a_valid, a_ready : index output handshake
//   remain            : indices still to emit, including the one on a
//   zero_err          : one-cycle pulse when an all-zero word is accepted
//   busy              : serving a word
module enc4to2_seq
    import enc_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  s,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [AW-1:0] a,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [AW:0]   remain,
    output logic          zero_err,
    output logic          busy
);
    logic          state, state_d;
    logic [N-1:0]  pending, pending_d, pend_next;
    logic [AW-1:0] a_d, s_idx, n_idx;
    logic [AW:0]   remain_d;
    logic          a_valid_d, zero_err_d, s_any, n_any, accept;

    assign s_ready = (state == ST_IDLE) && en;
    assign busy = (state == ST_SERVE);
    assign accept = s_valid && s_ready;
    // pending with the index currently on a already delivered
    assign pend_next = pending & ~(N'(1) << a);

    lsb_find #(.N(N), .AW(AW)) u_load (.vec(s), .idx(s_idx), .any(s_any));
    lsb_find #(.N(N), .AW(AW)) u_next (.vec(pend_next), .idx(n_idx), .any(n_any));

    always_comb begin
        state_d = state;
        pending_d = pending;
        a_d = a;
        a_valid_d = a_valid;
        remain_d = remain;
        zero_err_d = 1'b0;
        if (state == ST_IDLE) begin
            zero_err_d = accept && !s_any;
            if (accept && s_any) begin
                pending_d = s;
                remain_d = (AW+1)'(popcount(64'(s), N));
                a_d = s_idx;
                a_valid_d = 1'b1;
                state_d = ST_SERVE;
            end
        end else if (!en) begin
            a_valid_d = 1'b0;
        end else if (!a_valid) begin
            // resuming after a pause re-presents the held index
            a_valid_d = 1'b1;
        end else if (a_ready) begin
            pending_d = pend_next;
            remain_d = remain - (AW+1)'(1);
            a_d = n_any ? n_idx : a;
            a_valid_d = n_any;
            state_d = n_any ? ST_SERVE : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pending <= '0;
            a <= '0;
            a_valid <= 1'b0;
            remain <= '0;
            zero_err <= 1'b0;
        end else begin
            state <= state_d;
            pending <= pending_d;
            a <= a_d;
            a_valid <= a_valid_d;
            remain <= remain_d;
            zero_err <= zero_err_d;
        end
    end
endmodule
